// File: rtl/mlp_pkg.sv
// Shared definitions for the tiny MLP core.
//   train_state_t : states of the training-step controller
//   X_W           : sample width feeding the forward datapath
//   EPOCH_W       : width of the completed-epoch count
//   SAMPLE_W      : width of the per-epoch sample count
//   N_HIDDEN_MAX  : largest hidden layer the datapath muxes support
package mlp_pkg;

    localparam int X_W          = 4;
    localparam int EPOCH_W      = 8;
    localparam int SAMPLE_W     = 8;
    localparam int N_HIDDEN_MAX = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT_SAMPLE,
        ST_FWD,
        ST_BP,
        ST_WB,
        ST_DONE
    } train_state_t;

endpackage

// File: rtl/train_epoch_counter.sv
// Sample and epoch bookkeeping for one training session.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   clear_i          : zero both counters (session start)
//   sample_inc_i     : one sample has finished its weight updates
//   epoch_o          : number of completed epochs
//   sample_wrap_o    : the current sample is the last one of its epoch
//   session_end_o    : the current epoch is the last one of the session;
//                      together with sample_wrap_o it marks the final sample
module train_epoch_counter
    import mlp_pkg::*;
#(
    parameter int N_SAMPLES = 16,
    parameter int N_EPOCH   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               sample_inc_i,
    output logic [EPOCH_W-1:0] epoch_o,
    output logic               sample_wrap_o,
    output logic               session_end_o
);

    localparam logic [SAMPLE_W-1:0] LAST_SAMPLE = SAMPLE_W'(N_SAMPLES - 1);
    localparam logic [EPOCH_W-1:0]  LAST_EPOCH  = EPOCH_W'(N_EPOCH - 1);

    logic [SAMPLE_W-1:0] sample_cnt;

    assign sample_wrap_o = (sample_cnt == LAST_SAMPLE);
    assign session_end_o = (epoch_o == LAST_EPOCH);

    // The sample count rolls over into the epoch count at the end of each epoch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sample_cnt <= '0;
            epoch_o    <= '0;
        end else if (clear_i) begin
            sample_cnt <= '0;
            epoch_o    <= '0;
        end else if (sample_inc_i) begin
            if (sample_wrap_o) begin
                sample_cnt <= '0;
                epoch_o    <= epoch_o + EPOCH_W'(1);
            end else begin
                sample_cnt <= sample_cnt + SAMPLE_W'(1);
            end
        end
    end

endmodule

// File: rtl/train_sequencer.sv
// Training-step controller: per sample runs one forward pass, then shares the
// single backprop unit across all hidden neurons (BP then WB per neuron).
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   start_i, abort_i      : begin a session (IDLE only) / return to IDLE
//   sample_valid_i, x_i   : sample handshake from the feeder
//   sample_ready_o, x_o   : ready in WAIT_SAMPLE / sample latched at acceptance
//   fwd_en_o, fwd_done_i  : forward datapath enable and completion
//   bp_en_o, bp_sel_o     : backprop unit enable and neuron routed to it
//   zero_weight_reset_o   : clear-weights pulse at session start
//   wr_en_o               : write backprop results into neuron bp_sel_o
//   epoch_o, busy_o, done_o : progress, activity and completion pulse
module train_sequencer
    import mlp_pkg::*;
#(
    parameter int  N_HIDDEN  = 4,
    parameter int  N_SAMPLES = 16,
    parameter int  N_EPOCH   = 16,
    localparam int SEL_W     = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               sample_valid_i,
    output logic               sample_ready_o,
    input  logic [X_W-1:0]     x_i,
    output logic [X_W-1:0]     x_o,
    output logic               fwd_en_o,
    input  logic               fwd_done_i,
    output logic               bp_en_o,
    output logic [SEL_W-1:0]   bp_sel_o,
    output logic               zero_weight_reset_o,
    output logic               wr_en_o,
    output logic [EPOCH_W-1:0] epoch_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_HIDDEN - 1);

    train_state_t     state;
    train_state_t     next_state;
    logic [SEL_W-1:0] sel_next;
    logic             cnt_clear;
    logic             sample_inc;
    logic             x_load;
    logic             sample_wrap;
    logic             session_end;

    train_epoch_counter #(
        .N_SAMPLES (N_SAMPLES),
        .N_EPOCH   (N_EPOCH)
    ) u_epoch_counter (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_i       (cnt_clear),
        .sample_inc_i  (sample_inc),
        .epoch_o       (epoch_o),
        .sample_wrap_o (sample_wrap),
        .session_end_o (session_end)
    );

    // Next-state and bookkeeping decisions. Abort is applied last so that it
    // overrides every other decision, including counter updates in WB.
    always_comb begin
        next_state = state;
        sel_next   = bp_sel_o;
        cnt_clear  = 1'b0;
        sample_inc = 1'b0;
        x_load     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start_i) begin
                    next_state = ST_CLEAR;
                    cnt_clear  = 1'b1;
                    sel_next   = '0;
                end
            end
            ST_CLEAR: next_state = ST_WAIT_SAMPLE;
            ST_WAIT_SAMPLE: begin
                if (sample_valid_i) begin
                    next_state = ST_FWD;
                    x_load     = 1'b1;
                end
            end
            ST_FWD: begin
                if (fwd_done_i) begin
                    next_state = ST_BP;
                    sel_next   = '0;
                end
            end
            ST_BP: next_state = ST_WB;
            ST_WB: begin
                if (bp_sel_o != LAST_SEL) begin
                    sel_next   = bp_sel_o + SEL_W'(1);
                    next_state = ST_BP;
                end else begin
                    sel_next   = '0;
                    sample_inc = 1'b1;
                    next_state = (sample_wrap && session_end) ? ST_DONE : ST_WAIT_SAMPLE;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase

        if (abort_i && (state != ST_IDLE)) begin
            next_state = ST_IDLE;
            sel_next   = bp_sel_o;
            cnt_clear  = 1'b0;
            sample_inc = 1'b0;
            x_load     = 1'b0;
        end
    end

    // State register plus registered Moore outputs decoded from the next state,
    // so every output changes cleanly on the clock edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state               <= ST_IDLE;
            bp_sel_o            <= '0;
            x_o                 <= '0;
            sample_ready_o      <= 1'b0;
            fwd_en_o            <= 1'b0;
            bp_en_o             <= 1'b0;
            wr_en_o             <= 1'b0;
            zero_weight_reset_o <= 1'b0;
            busy_o              <= 1'b0;
            done_o              <= 1'b0;
        end else begin
            state               <= next_state;
            bp_sel_o            <= sel_next;
            if (x_load) begin
                x_o <= x_i;
            end
            sample_ready_o      <= (next_state == ST_WAIT_SAMPLE);
            fwd_en_o            <= (next_state == ST_FWD);
            bp_en_o             <= (next_state == ST_BP);
            wr_en_o             <= (next_state == ST_WB);
            zero_weight_reset_o <= (next_state == ST_CLEAR);
            busy_o              <= (next_state != ST_IDLE);
            done_o              <= (next_state == ST_DONE);
        end
    end

endmodule

// File: tb/tb_train_sequencer.sv
// Self-checking bench for train_sequencer with N_HIDDEN=4, N_SAMPLES=2,
// N_EPOCH=3. Expected behaviour comes from per-sample arithmetic: neuron
// indices 0..N_HIDDEN-1 per sample, epoch = samples / N_SAMPLES, and
// completion after N_SAMPLES*N_EPOCH samples.
module tb_train_sequencer;

    localparam int N_HIDDEN  = 4;
    localparam int N_SAMPLES = 2;
    localparam int N_EPOCH   = 3;
    localparam int SEL_W     = $clog2(N_HIDDEN);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic             sample_valid;
    logic             sample_ready;
    logic [3:0]       x;
    logic [3:0]       x_out;
    logic             fwd_en;
    logic             fwd_done;
    logic             bp_en;
    logic [SEL_W-1:0] bp_sel;
    logic             zwr;
    logic             wr_en;
    logic [7:0]       epoch;
    logic             busy;
    logic             done;

    logic [18+SEL_W:0] all_outs;
    assign all_outs = {sample_ready, x_out, fwd_en, bp_en, bp_sel, zwr, wr_en, epoch, busy, done};

    int n_cmp = 0;
    int n_err = 0;

    int         obs_timeout;
    logic [3:0] obs_xo;
    int         obs_fwd_bad;
    int         obs_pair_bad;
    int         obs_wr;
    int         obs_zwr;

    always #5 clk = ~clk;

    train_sequencer #(
        .N_HIDDEN  (N_HIDDEN),
        .N_SAMPLES (N_SAMPLES),
        .N_EPOCH   (N_EPOCH)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .start_i             (start),
        .abort_i             (abort),
        .sample_valid_i      (sample_valid),
        .sample_ready_o      (sample_ready),
        .x_i                 (x),
        .x_o                 (x_out),
        .fwd_en_o            (fwd_en),
        .fwd_done_i          (fwd_done),
        .bp_en_o             (bp_en),
        .bp_sel_o            (bp_sel),
        .zero_weight_reset_o (zwr),
        .wr_en_o             (wr_en),
        .epoch_o             (epoch),
        .busy_o              (busy),
        .done_o              (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Drives one sample through acceptance, a forward pass of fwd_cycles cycles
    // and the BP/WB pairs, recording what it observed into the obs_* variables.
    task automatic drive_sample(input logic [3:0] xv, input int fwd_cycles,
                                input int gap, input int start_at_bp);
        int waited;
        obs_timeout  = 0;
        obs_xo       = '0;
        obs_fwd_bad  = 0;
        obs_pair_bad = 0;
        obs_wr       = 0;
        obs_zwr      = 0;
        waited       = 0;
        while (sample_ready !== 1'b1 && waited < 50) begin
            step();
            waited++;
        end
        if (sample_ready !== 1'b1) obs_timeout = 1;
        for (int g = 0; g < gap; g++) begin
            if (sample_ready !== 1'b1 || fwd_en !== 1'b0) obs_fwd_bad++;
            step();
        end
        x            = xv;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        x            = ~xv;
        for (int k = 1; k <= fwd_cycles; k++) begin
            if (fwd_en !== 1'b1 || sample_ready !== 1'b0 || bp_en !== 1'b0) obs_fwd_bad++;
            obs_xo   = x_out;
            fwd_done = (k == fwd_cycles);
            step();
        end
        fwd_done = 1'b0;
        for (int j = 0; j < N_HIDDEN; j++) begin
            if (bp_en !== 1'b1 || wr_en !== 1'b0 || bp_sel !== SEL_W'(j)) obs_pair_bad++;
            if (zwr !== 1'b0) obs_zwr++;
            start = (j == start_at_bp);
            step();
            start = 1'b0;
            if (wr_en !== 1'b1 || bp_en !== 1'b0 || bp_sel !== SEL_W'(j)) obs_pair_bad++;
            if (zwr !== 1'b0) obs_zwr++;
            if (wr_en === 1'b1) obs_wr++;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; sample_valid = 1'b0;
        x = 4'h0; fwd_done = 1'b0;
        #2;
        n_cmp++;
        if (all_outs !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs: got %0h expected 0", all_outs);
        end
        step();
        step();
        rst = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0 || epoch !== 8'd0) begin
            n_err++;
            $display("[TB] FAIL idle_after_reset: busy=%0b epoch=%0d expected 0/0", busy, epoch);
        end
    endtask

    task automatic test_full_session(input int rep);
        logic [3:0] xv;
        int fc;
        int gp;
        int wr_total;
        int done_cnt;
        int exp_epoch;
        logic exp_done;
        wr_total = 0;
        done_cnt = 0;
        start_session();
        n_cmp++;
        if (zwr !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL start_clear: zwr=%0b busy=%0b expected 1/1", zwr, busy);
        end
        step();
        for (int s = 0; s < N_SAMPLES * N_EPOCH; s++) begin
            xv = (rep == 0 && s == 0) ? 4'b1010 : 4'($urandom);
            fc = (rep == 0 && s == 0) ? 3 : int'($urandom_range(1, 4));
            gp = int'($urandom_range(0, 3));
            drive_sample(xv, fc, gp, -1);
            wr_total += obs_wr;
            if (done === 1'b1) done_cnt++;
            exp_epoch = (s + 1) / N_SAMPLES;
            exp_done  = ((s + 1) == N_SAMPLES * N_EPOCH);
            n_cmp++;
            if (obs_timeout != 0 || obs_fwd_bad != 0) begin
                n_err++;
                $display("[TB] FAIL fwd_phase s%0d: timeout=%0d bad=%0d expected 0/0", s, obs_timeout, obs_fwd_bad);
            end
            n_cmp++;
            if (obs_xo !== xv) begin
                n_err++;
                $display("[TB] FAIL x_latch s%0d: got %0h expected %0h", s, obs_xo, xv);
            end
            n_cmp++;
            if (obs_pair_bad != 0) begin
                n_err++;
                $display("[TB] FAIL bp_wb_pairs s%0d: bad cycles %0d expected 0", s, obs_pair_bad);
            end
            n_cmp++;
            if (epoch !== 8'(exp_epoch)) begin
                n_err++;
                $display("[TB] FAIL epoch s%0d: got %0d expected %0d", s, epoch, exp_epoch);
            end
            n_cmp++;
            if (done !== exp_done || sample_ready !== !exp_done) begin
                n_err++;
                $display("[TB] FAIL sample_end s%0d: done=%0b ready=%0b expected %0b/%0b",
                         s, done, sample_ready, exp_done, !exp_done);
            end
        end
        step();
        if (done === 1'b1) done_cnt++;
        n_cmp++;
        if (busy !== 1'b0 || epoch !== 8'(N_EPOCH)) begin
            n_err++;
            $display("[TB] FAIL session_idle: busy=%0b epoch=%0d expected 0/%0d", busy, epoch, N_EPOCH);
        end
        n_cmp++;
        if (wr_total != N_HIDDEN * N_SAMPLES * N_EPOCH || done_cnt != 1) begin
            n_err++;
            $display("[TB] FAIL session_totals: wr=%0d done=%0d expected %0d/1",
                     wr_total, done_cnt, N_HIDDEN * N_SAMPLES * N_EPOCH);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        start_session();
        step();
        sample_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (sample_ready !== 1'b1 || busy !== 1'b1 || fwd_en !== 1'b0) bad++;
            step();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("[TB] FAIL backpressure: bad cycles %0d expected 0", bad);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || sample_ready !== 1'b0 || epoch !== 8'd0) begin
            n_err++;
            $display("[TB] FAIL abort_wait: busy=%0b ready=%0b epoch=%0d expected 0/0/0", busy, sample_ready, epoch);
        end
    endtask

    task automatic test_abort_fwd_done();
        int bad;
        bad = 0;
        start_session();
        step();
        drive_sample(4'($urandom), 1, 0, -1);
        drive_sample(4'($urandom), 2, 1, -1);
        n_cmp++;
        if (epoch !== 8'd1) begin
            n_err++;
            $display("[TB] FAIL epoch_before_abort: got %0d expected 1", epoch);
        end
        x = 4'($urandom);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        step();
        fwd_done = 1'b1;
        abort    = 1'b1;
        step();
        fwd_done = 1'b0;
        abort    = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || bp_en !== 1'b0 || done !== 1'b0 || fwd_en !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL abort_fwd_done: busy=%0b bp_en=%0b done=%0b fwd_en=%0b expected 0",
                     busy, bp_en, done, fwd_en);
        end
        n_cmp++;
        if (epoch !== 8'd1) begin
            n_err++;
            $display("[TB] FAIL epoch_after_abort: got %0d expected 1", epoch);
        end
        for (int i = 0; i < 5; i++) begin
            if (bp_en !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
            step();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("[TB] FAIL quiet_after_abort: bad cycles %0d expected 0", bad);
        end
    endtask

    task automatic test_start_during_bp();
        start_session();
        step();
        drive_sample(4'($urandom), 1, 0, 1);
        n_cmp++;
        if (obs_pair_bad != 0 || obs_zwr != 0) begin
            n_err++;
            $display("[TB] FAIL start_in_bp: pair bad %0d zwr %0d expected 0/0", obs_pair_bad, obs_zwr);
        end
        n_cmp++;
        if (obs_wr != N_HIDDEN || sample_ready !== 1'b1 || epoch !== 8'd0) begin
            n_err++;
            $display("[TB] FAIL start_in_bp_end: wr=%0d ready=%0b epoch=%0d expected %0d/1/0",
                     obs_wr, sample_ready, epoch, N_HIDDEN);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_reset_mid_fwd();
        start_session();
        step();
        x = 4'b0110;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        step();
        n_cmp++;
        if (fwd_en !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL in_fwd: fwd_en=%0b expected 1", fwd_en);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (all_outs !== '0) begin
            n_err++;
            $display("[TB] FAIL async_reset: got %0h expected 0", all_outs);
        end
        step();
        rst = 1'b0;
        step();
        start_session();
        n_cmp++;
        if (zwr !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL restart_clear: zwr=%0b expected 1", zwr);
        end
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_full_session(0);
        test_full_session(1);
        test_backpressure();
        test_abort_fwd_done();
        test_start_during_bp();
        test_reset_mid_fwd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/train_sequencer.md
# train_sequencer

Training-step controller for the tiny MLP core. It runs a training session of `N_EPOCH` epochs of `N_SAMPLES` samples each. For every sample it runs one forward pass, then time-multiplexes the single shared hidden-layer backprop unit across all `N_HIDDEN` hidden neurons, writing each neuron's updated weights back in turn. It sits between the host/sample-feeder interface and the forward datapath, the shared backprop unit and the weight registers.

## Interface
Parameters:
- `N_HIDDEN`, default 4: hidden neurons sharing the backprop unit; range 1..8.
- `N_SAMPLES`, default 16: samples per epoch; range 1..255.
- `N_EPOCH`, default 16: epochs per session; range 1..255.

Ports (name, direction, width, meaning):
- `clk_i`  in  1: the single clock; all state changes on its rising edge.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `start_i`  in  1: begin a session; sampled only in IDLE.
- `abort_i`  in  1: synchronous abort; returns the block to IDLE.
- `sample_valid_i`  in  1: feeder presents a sample.
- `sample_ready_o`  out  1: block accepts a sample; high only in WAIT_SAMPLE.
- `x_i`  in  4: sample bits.
- `x_o`  out  4: sample latched at acceptance; drives the datapath `x_i`.
- `fwd_en_o`  out  1: forward datapath enable.
- `fwd_done_i`  in  1: forward result (`final`) is valid.
- `bp_en_o`  out  1: drives the backprop unit `en_i`.
- `bp_sel_o`  out  `$clog2(N_HIDDEN)` (min 1): hidden neuron routed to the backprop unit.
- `zero_weight_reset_o`  out  1: clear-weights pulse to the backprop unit.
- `wr_en_o`  out  1: write the backprop outputs into neuron `bp_sel_o`'s weight registers.
- `epoch_o`  out  8: completed epochs.
- `busy_o`  out  1: high in every state except IDLE.
- `done_o`  out  1: one-cycle pulse when the session completes.

## Operation
States: IDLE, CLEAR, WAIT_SAMPLE, FWD, BP, WB, DONE.
- **IDLE:** `start_i`=1 → CLEAR. The sample counter, `epoch_o` and `bp_sel_o` are cleared on this transition.
- **CLEAR:** lasts 1 cycle. `zero_weight_reset_o`=1, then → WAIT_SAMPLE.
- **WAIT_SAMPLE:** `sample_ready_o`=1. When `sample_valid_i`=1: latch `x_i` into `x_o` and go → FWD.
- **FWD:** `fwd_en_o`=1 and is held until `fwd_done_i`=1 is sampled, then → BP with `bp_sel_o`=0.
- **BP:** lasts 1 cycle. `bp_en_o`=1, then → WB.
- **WB:** lasts 1 cycle. `wr_en_o`=1. Then:
  - if `bp_sel_o` < `N_HIDDEN`-1: increment `bp_sel_o` and go → BP;
  - otherwise the sample is finished: clear `bp_sel_o` and increment the sample counter.
    - If the counter reaches `N_SAMPLES`: clear it and increment `epoch_o`.
    - If `epoch_o` reaches `N_EPOCH` → DONE; otherwise → WAIT_SAMPLE.
- **DONE:** lasts 1 cycle. `done_o`=1, then → IDLE. `epoch_o` holds its final value until the next start.
- **`abort_i`=1** in any non-IDLE state: → IDLE next cycle. No `done_o`, no `wr_en_o` pulse; `epoch_o` holds its value. Abort wins over `fwd_done_i`, `sample_valid_i` and every WB decision.
- `start_i` outside IDLE is ignored. `sample_valid_i` outside WAIT_SAMPLE is ignored.
- Counter arithmetic is unsigned. The sample counter is 8 bits and `epoch_o` is 8 bits; neither can wrap within the legal parameter ranges.

## Timing
- All outputs are registered (Moore).
- Reset values: every output is 0, `x_o`=0, state=IDLE, counters=0.
- Asserting `rst_i` mid-session forces IDLE immediately, independent of the clock. The session is lost and the weight registers are untouched, because `wr_en_o`=0.
- `start_i` to `zero_weight_reset_o`: 1 cycle.
- The `bp_en_o` edge updates the backprop output registers; `wr_en_o` follows in the very next cycle so that the write captures the freshly registered weights.
- Per-sample latency, from the acceptance edge to the return to WAIT_SAMPLE: (FWD cycles) + 2·`N_HIDDEN`. If `fwd_done_i` is already high on FWD entry, FWD lasts 1 cycle, giving 1 + 2·`N_HIDDEN` = 9 cycles at the default.
- `bp_sel_o` is stable during each BP/WB pair.

## Structure
- A shared package `mlp_pkg` holds:
  - the state enum `train_state_t`;
  - `X_W`=4;
  - `EPOCH_W`=8;
  - a `N_HIDDEN_MAX`=8 constant, reused by the datapath muxes.
- One sub-module, `train_epoch_counter`, holds the sample and epoch counters. It takes clear/increment inputs and produces `epoch_o` plus `sample_wrap` and `session_end` flags. The FSM and the neuron-select counter stay in the top module.

## Test plan
- Reset mid-FWD with `N_HIDDEN`=4: assert `rst_i` → all outputs read 0 immediately; a subsequent `start_i` yields `zero_weight_reset_o` 1 cycle later.
- One sample (`N_SAMPLES`=1, `N_EPOCH`=1), `x_i`=4'b1010, `fwd_done_i` high after 3 FWD cycles → `x_o`=4'b1010, then `bp_en_o`/`wr_en_o` alternate with `bp_sel_o`=0,1,2,3, then `done_o` for 1 cycle and `epoch_o`=1.
- Full session with `N_SAMPLES`=2, `N_EPOCH`=3 → exactly 6 samples accepted, 24 `wr_en_o` pulses, `epoch_o` stepping 1,2,3, and a single `done_o`.
- Backpressure: hold `sample_valid_i` low for 10 cycles in WAIT_SAMPLE → no `fwd_en_o`, `sample_ready_o` stays 1, `busy_o` stays 1.
- Abort in the same cycle as `fwd_done_i` → IDLE next cycle, no `bp_en_o`, no `done_o`, `epoch_o` unchanged.
- `start_i` pulsed during BP → ignored; the sequence continues with `bp_sel_o` unchanged.
